// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and sizes for the SRAM front-end controller
package sram_ctrl_pkg;

    typedef enum logic {CLEAR, SERVE} sram_ctrl_state_t;
    typedef enum logic {GNT_A, GNT_B} sram_grant_t;

    localparam int SRAM_ADDR_W = 5;
    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_DEPTH  = 32;

endpackage

// File: rtl/sram_arbiter_ctrl_rr_arb2.sv
// rtl/sram_arbiter_ctrl_rr_arb2.sv - two-requester round-robin arbiter with hold-off
module rr_arb2
    import sram_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic hold_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    sram_grant_t last_q, last_d;
    logic        win_a, win_b;

    always_comb begin
        win_a  = 1'b0;
        win_b  = 1'b0;
        last_d = last_q;
        if (!hold_i) begin
            // On a tie the requester that did not win last time goes first.
            if (req_a_i && (!req_b_i || last_q == GNT_B)) begin
                win_a = 1'b1;
            end else if (req_b_i) begin
                win_b = 1'b1;
            end
        end
        if (win_a) begin
            last_d = GNT_A;
        end else if (win_b) begin
            last_d = GNT_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GNT_B;
        end else begin
            last_q <= last_d;
        end
    end

    assign gnt_a_o = win_a;
    assign gnt_b_o = win_b;

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// rtl/sram_arbiter_ctrl.sv - SRAM front end: zero-fill sequencer plus fetch/load-store port sharing
module sram_arbiter_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int                ADDR_W         = SRAM_ADDR_W,
    parameter int                DATA_W         = SRAM_DATA_W,
    parameter int                DEPTH          = SRAM_DEPTH,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_clear,
    output logic              clear_busy,
    output logic              clear_done,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              init_en,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data
);

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

    sram_ctrl_state_t  state_q, state_d;
    logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
    logic              clear_done_q, clear_done_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              in_clear;
    logic              hold;

    assign in_clear = (state_q == CLEAR);
    // start_clear wins over any pending request in the cycle it is seen.
    assign hold     = in_clear || start_clear;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .hold_i  (hold),
        .req_a_i (a_req),
        .req_b_i (b_req),
        .gnt_a_o (a_gnt),
        .gnt_b_o (b_gnt)
    );

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        clear_done_d = 1'b0;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + (ADDR_W+1)'(1);
            if (clr_cnt_q == LAST_CNT) begin
                state_d      = SERVE;
                clear_done_d = 1'b1;
            end
        end else if (start_clear) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
        end
    end

    always_comb begin
        a_rvalid_d = a_gnt;
        a_rdata_d  = a_gnt ? sram_rdata : a_rdata_q;
        b_rvalid_d = b_gnt && !b_we;
        b_rdata_d  = (b_gnt && !b_we) ? sram_rdata : b_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR_ON_RESET ? CLEAR : SERVE;
            clr_cnt_q    <= '0;
            clear_done_q <= 1'b0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            clear_done_q <= clear_done_d;
            a_rvalid_q   <= a_rvalid_d;
            b_rvalid_q   <= b_rvalid_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign clear_busy = in_clear;
    assign clear_done = clear_done_q;
    assign a_rvalid   = a_rvalid_q;
    assign a_rdata    = a_rdata_q;
    assign b_rvalid   = b_rvalid_q;
    assign b_rdata    = b_rdata_q;

    assign sram_ce    = a_gnt || b_gnt;
    assign sram_we    = b_gnt && b_we;
    assign sram_addr  = b_gnt ? b_addr : (a_gnt ? a_addr : '0);
    assign sram_wdata = (b_gnt && b_we) ? b_wdata : '0;

    assign init_en    = in_clear;
    assign init_we    = in_clear;
    assign init_addr  = clr_cnt_q[ADDR_W-1:0];
    assign init_data  = in_clear ? CLEAR_VALUE : '0;

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// tb/tb_sram_arbiter_ctrl.sv - self-checking bench for sram_arbiter_ctrl with an SRAM model
module tb_sram_arbiter_ctrl;

    logic        clk = 1'b0;
    logic        rst, start_clear;
    logic        clear_busy, clear_done;
    logic        a_req, a_gnt, a_rvalid;
    logic [4:0]  a_addr;
    logic [31:0] a_rdata;
    logic        b_req, b_we, b_gnt, b_rvalid;
    logic [4:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic        sram_ce, sram_we, init_en, init_we;
    logic [4:0]  sram_addr, init_addr;
    logic [31:0] sram_wdata, sram_rdata, init_data;

    always #5 clk = ~clk;

    sram_arbiter_ctrl dut (
        .clk(clk), .rst(rst), .start_clear(start_clear),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .init_en(init_en), .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
    );

    // Physical SRAM: init port has priority, combinational read.
    logic [31:0] sram_mem [32];
    initial for (int i = 0; i < 32; i++) sram_mem[i] = 32'h0;
    always @(posedge clk) begin
        if (init_en && init_we) sram_mem[init_addr] <= init_data;
        else if (sram_ce && sram_we) sram_mem[sram_addr] <= sram_wdata;
    end
    assign sram_rdata = sram_mem[sram_addr];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Reference model: contents, whether a clear is running, which write it is on, who won last.
    bit          m_valid = 0;
    bit          m_clear, m_last_a;
    int          m_cnt;
    logic [31:0] m_mem [32];
    bit          m_arv, m_brv, m_done;
    logic [31:0] m_ard, m_brd;
    bit          e_ga, e_gb;
    int          busy_cnt, done_cnt, gnt_cnt, cyc_idx, done_cyc;

    initial for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;

    task automatic set_in(input bit r, input bit sc, input bit ar, input logic [4:0] aa,
                          input bit br, input bit bw, input logic [4:0] ba, input logic [31:0] bd);
        rst = r; start_clear = sc; a_req = ar; a_addr = aa;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    endtask

    task automatic cycle();
        bit          n_arv, n_brv;
        logic [31:0] n_ard, n_brd;
        #1;
        e_ga = 0;
        e_gb = 0;
        if (!m_clear && !start_clear) begin
            e_ga = a_req && (!b_req || !m_last_a);
            e_gb = b_req && !e_ga;
        end
        if (m_valid) begin
            chk("a_gnt", a_gnt, e_ga);
            chk("b_gnt", b_gnt, e_gb);
            chk("clear_busy", clear_busy, m_clear);
            chk("init_en", init_en & init_we, m_clear);
            if (m_clear) begin
                chk("init_addr", init_addr, 32'(m_cnt));
                chk("init_data", init_data, 32'h0);
            end
            chk("sram_ce", sram_ce, e_ga | e_gb);
            chk("sram_we", sram_we, e_gb & b_we);
            if (e_ga | e_gb) chk("sram_addr", sram_addr, e_gb ? b_addr : a_addr);
            if (e_gb & b_we) chk("sram_wdata", sram_wdata, b_wdata);
            chk("a_rvalid", a_rvalid, m_arv);
            if (m_arv) chk("a_rdata", a_rdata, m_ard);
            chk("b_rvalid", b_rvalid, m_brv);
            if (m_brv) chk("b_rdata", b_rdata, m_brd);
            chk("clear_done", clear_done, m_done);
        end
        cyc_idx++;
        if (clear_busy) busy_cnt++;
        if (clear_done) begin done_cnt++; done_cyc = cyc_idx; end
        if (a_gnt || b_gnt) gnt_cnt++;
        @(posedge clk);
        n_arv = e_ga;
        n_ard = e_ga ? m_mem[a_addr] : m_ard;
        n_brv = e_gb && !b_we;
        n_brd = (e_gb && !b_we) ? m_mem[b_addr] : m_brd;
        if (m_valid) begin
            if (m_clear) m_mem[m_cnt] = 32'h0;
            else if (e_gb && b_we) m_mem[b_addr] = b_wdata;
        end
        if (rst) begin
            m_valid = 1; m_clear = 1; m_cnt = 0; m_last_a = 0;
            m_arv = 0; m_brv = 0; m_done = 0; m_ard = 0; m_brd = 0;
        end else if (m_valid) begin
            m_arv = n_arv; m_ard = n_ard; m_brv = n_brv; m_brd = n_brd;
            if (e_ga || e_gb) m_last_a = e_ga;
            m_done = m_clear && (m_cnt == 31);
            if (m_clear) begin
                if (m_cnt == 31) m_clear = 0;
                m_cnt++;
            end else if (start_clear) begin
                m_clear = 1;
                m_cnt = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    typedef struct {
        bit          a_req;
        logic [4:0]  a_addr;
        bit          b_req;
        bit          b_we;
        logic [4:0]  b_addr;
        logic [31:0] b_wdata;
        bit          ea, eb, earv, ebrv;
        logic [31:0] eard, ebrd;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{0, 5'd0, 1, 1, 5'd1, 32'h11111111, 0, 1, 0, 0, 32'h0, 32'h0};
        tbl[1] = '{0, 5'd0, 1, 1, 5'd2, 32'h22222222, 0, 1, 0, 0, 32'h0, 32'h0};
        tbl[2] = '{0, 5'd0, 1, 1, 5'd7, 32'hDEADBEEF, 0, 1, 0, 0, 32'h0, 32'h0};
        tbl[3] = '{1, 5'd7, 0, 0, 5'd0, 32'h0,        1, 0, 0, 0, 32'h0, 32'h0};
        tbl[4] = '{1, 5'd1, 1, 0, 5'd2, 32'h0,        0, 1, 1, 0, 32'hDEADBEEF, 32'h0};
        tbl[5] = '{1, 5'd1, 1, 0, 5'd2, 32'h0,        1, 0, 0, 1, 32'h0, 32'h22222222};
        tbl[6] = '{1, 5'd1, 1, 0, 5'd2, 32'h0,        0, 1, 1, 0, 32'h11111111, 32'h0};
        tbl[7] = '{1, 5'd1, 1, 0, 5'd2, 32'h0,        1, 0, 0, 1, 32'h0, 32'h22222222};
        tbl[8] = '{0, 5'd0, 0, 0, 5'd0, 32'h0,        0, 0, 1, 0, 32'h11111111, 32'h0};
        tbl[9] = '{0, 5'd0, 0, 0, 5'd0, 32'h0,        0, 0, 0, 0, 32'h0, 32'h0};

        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        run(2);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_a_rdata", a_rdata, 32'h0);
        chk("rst_b_rdata", b_rdata, 32'h0);
        chk("rst_init_addr", init_addr, 32'h0);
        busy_cnt = 0; done_cnt = 0; cyc_idx = 0; done_cyc = -1; gnt_cnt = 0;
        run(34);
        chk("init_busy_cycles", busy_cnt, 32);
        chk("init_done_cycle", done_cyc, 33);
        chk("init_done_count", done_cnt, 1);

        for (int i = 0; i < 10; i++) begin
            set_in(0, 0, tbl[i].a_req, tbl[i].a_addr, tbl[i].b_req, tbl[i].b_we,
                   tbl[i].b_addr, tbl[i].b_wdata);
            #1;
            chk($sformatf("tbl%0d_a_gnt", i), a_gnt, tbl[i].ea);
            chk($sformatf("tbl%0d_b_gnt", i), b_gnt, tbl[i].eb);
            chk($sformatf("tbl%0d_a_rvalid", i), a_rvalid, tbl[i].earv);
            chk($sformatf("tbl%0d_b_rvalid", i), b_rvalid, tbl[i].ebrv);
            if (tbl[i].earv) chk($sformatf("tbl%0d_a_rdata", i), a_rdata, tbl[i].eard);
            if (tbl[i].ebrv) chk($sformatf("tbl%0d_b_rdata", i), b_rdata, tbl[i].ebrd);
            cycle();
        end

        // start_clear beats a pending fetch; the fetch is served after the clear.
        set_in(0, 0, 0, 0, 1, 1, 5'd31, 32'h12345678);
        cycle();
        set_in(0, 1, 1, 5'd31, 0, 0, 0, 0);
        #1;
        chk("sc_no_a_gnt", a_gnt, 0);
        chk("sc_no_ce", sram_ce, 0);
        cycle();
        set_in(0, 0, 1, 5'd31, 0, 0, 0, 0);
        busy_cnt = 0; gnt_cnt = 0;
        run(32);
        chk("sc_busy_cycles", busy_cnt, 32);
        chk("sc_no_gnt_in_clear", gnt_cnt, 0);
        #1;
        chk("sc_done", clear_done, 1);
        chk("sc_gnt_after", a_gnt, 1);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sc_rd31_valid", a_rvalid, 1);
        chk("sc_rd31_data", a_rdata, 32'h0);
        cycle();

        // Reset in the middle of a clear restarts it from address 0.
        set_in(0, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        run(10);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_mid_addr0", init_addr, 32'h0);
        busy_cnt = 0; done_cnt = 0;
        run(40);
        chk("rst_mid_busy", busy_cnt, 32);
        chk("rst_mid_done_once", done_cnt, 1);

        // Read granted just before start_clear still returns its data.
        set_in(0, 0, 0, 0, 1, 1, 5'd3, 32'h33333333);
        cycle();
        set_in(0, 0, 1, 5'd3, 0, 0, 0, 0);
        cycle();
        set_in(0, 1, 1, 5'd3, 0, 0, 0, 0);
        #1;
        chk("late_rd_valid", a_rvalid, 1);
        chk("late_rd_data", a_rdata, 32'h33333333);
        chk("late_no_gnt", a_gnt, 0);
        cycle();
        set_in(0, 0, 1, 5'd3, 0, 0, 0, 0);
        gnt_cnt = 0;
        run(32);
        chk("late_no_gnt_clear", gnt_cnt, 0);
        run(2);

        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 249) == 0, $urandom_range(0, 59) == 0,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), $urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
